// File: rtl/code_verifier_pkg.sv
// Shared types and default sizing for the code_verifier block.
package code_verifier_pkg;

    localparam int DEFAULT_DIGITS  = 4;
    localparam int DEFAULT_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REPORT,
        HOLD
    } cv_state_t;

endpackage

// File: rtl/code_verifier_digit_buffer.sv
// Capture register file for entered digits with a saturating fill counter,
// synchronous clear and an indexed read port.
module digit_buffer
    import code_verifier_pkg::*;
#(
    parameter int DIGITS  = DEFAULT_DIGITS,
    parameter int DIGIT_W = DEFAULT_DIGIT_W,
    parameter int CNT_W   = $clog2(DIGITS + 1),
    parameter int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic               clear,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DIGIT_W-1:0] rd_data,
    output logic [CNT_W-1:0]   count
);

    logic [DIGIT_W-1:0] mem [DIGITS];

    // NOTE: the storage array is reset explicitly because a missing digit must
    // read back as a known value, not X, after reset or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) mem[i] <= '0;
            count <= '0;
        end else if (clear) begin
            for (int i = 0; i < DIGITS; i++) mem[i] <= '0;
            count <= '0;
        end else if (wr_en && (count < CNT_W'(DIGITS))) begin
            mem[count[IDX_W-1:0]] <= wr_data;
            count                 <= count + CNT_W'(1);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/code_verifier.sv
// Captures user digits, then compares them one per cycle against KEY.
// Optional macro CODE_VERIFIER_EARLY_EXIT_EN stops the compare at the first mismatch.
module code_verifier
    import code_verifier_pkg::*;
#(
    parameter int                          DIGITS  = DEFAULT_DIGITS,
    parameter int                          DIGIT_W = DEFAULT_DIGIT_W,
    parameter logic [DIGITS*DIGIT_W-1:0]   KEY     = 16'h1234
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          waiting_for_user,
    input  logic                          digit_valid,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          start_verification,
    output logic                          final_analysis,
    output logic                          match,
    output logic [$clog2(DIGITS+1)-1:0]   mismatch_count,
    output logic [$clog2(DIGITS+1)-1:0]   digits_entered,
    output logic                          busy
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    cv_state_t          state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [DIGIT_W-1:0] rd_data;
    logic [DIGIT_W-1:0] key_digits [DIGITS];
    logic               capture, clear, last_idx, digit_bad;
    logic [CNT_W-1:0]   count_next;

    // Digit 0 of the key sits in the most significant bits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_key
        assign key_digits[g] = KEY[(DIGITS-1-g)*DIGIT_W +: DIGIT_W];
    end

    assign capture = (state == IDLE) && waiting_for_user && digit_valid && !start_verification;
    assign clear   = (state == HOLD) && waiting_for_user && !start_verification;

    digit_buffer #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (digit_in),
        .clear   (clear),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .count   (digits_entered)
    );

    assign last_idx   = (idx == IDX_W'(DIGITS - 1));
    assign digit_bad  = (CNT_W'(idx) >= digits_entered) || (rd_data != key_digits[idx]);
    assign count_next = mismatch_count + CNT_W'(digit_bad);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_verification) state_next = COMPARE;
`ifdef CODE_VERIFIER_EARLY_EXIT_EN
            COMPARE: if (last_idx || digit_bad) state_next = REPORT;
`else
            COMPARE: if (last_idx) state_next = REPORT;
`endif
            REPORT:  state_next = HOLD;
            HOLD:    if (clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            mismatch_count <= '0;
            match          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_verification) begin
                    idx            <= '0;
                    mismatch_count <= '0;
                    match          <= 1'b0;
                end
                COMPARE: begin
                    mismatch_count <= count_next;
                    if (state_next == REPORT) match <= (count_next == '0);
                    else                      idx   <= idx + IDX_W'(1);
                end
                HOLD: if (clear) begin
                    mismatch_count <= '0;
                    match          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign final_analysis = (state == REPORT);
    assign busy           = (state == COMPARE) || (state == REPORT);

endmodule

// File: doc/code_verifier.md
Name: code_verifier

Overview:
- Verification stage directly downstream of the top-level control FSM.
- Captures user digits while the FSM reports `waiting_for_user`.
- On `start_verification`, compares the captured digits one per cycle against a parameterised key.
- Returns `final_analysis` to the FSM, which then moves to `done`; the result (`match`, mismatch count) is held for display.

Parameters:
- DIGITS, 4, number of digits in the key/code
- DIGIT_W, 4, bits per digit
- KEY, 16'h1234, packed key (DIGITS*DIGIT_W bits); digit 0 in the MSBs

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- waiting_for_user  in  1  FSM idle/entry phase; enables digit capture
- digit_valid  in  1  one-cycle strobe, digit_in valid
- digit_in  in  DIGIT_W  entered digit
- start_verification  in  1  level from FSM; begin comparison
- final_analysis  out  1  one-cycle pulse, comparison complete
- match  out  1  1 = all DIGITS digits entered and equal to KEY
- mismatch_count  out  $clog2(DIGITS+1)  digits wrong or missing
- digits_entered  out  $clog2(DIGITS+1)  digits captured so far
- busy  out  1  high in COMPARE or REPORT

Behaviour:
- Reset (async, any state, including mid-compare):
  - state=IDLE.
  - All outputs 0: final_analysis, match, mismatch_count, digits_entered, busy.
  - Buffer cleared to 0; compare index = 0.
- IDLE:
  - Capture rule: waiting_for_user & digit_valid & digits_entered<DIGITS → buf[digits_entered]<=digit_in, digits_entered++.
  - Digits beyond DIGITS are ignored silently; the count saturates at DIGITS.
  - digit_valid with waiting_for_user=0 is ignored.
  - start_verification=1 sampled → COMPARE, idx=0, mismatch_count=0, match=0. Start takes priority: a digit_valid in the same cycle is dropped.
- COMPARE:
  - Each cycle, digit idx is a mismatch if idx>=digits_entered or buf[idx]!=KEY digit idx; mismatch_count increments on a mismatch.
  - idx==DIGITS-1 → REPORT; otherwise idx++.
  - Digit capture is disabled.
  - start_verification deassertion is ignored; the compare always completes.
- REPORT:
  - final_analysis=1 for exactly this one cycle.
  - match=(mismatch_count==0), registered on entry to REPORT and valid in the same cycle as final_analysis.
  - → HOLD.
- HOLD:
  - final_analysis=0; match, mismatch_count and digits_entered are held.
  - waiting_for_user=1 & start_verification=0 → IDLE, clearing buffer, digits_entered, match and mismatch_count.
  - Otherwise the block stays in HOLD (the current FSM stays done until rst).
- Latency: final_analysis is high in the cycle following the (DIGITS+1)-th rising edge counted from, and including, the edge that samples start_verification. Default: 5 edges.
- mismatch_count arithmetic: unsigned, cannot exceed DIGITS, no wrap.

Optional Feature:
- Macro: CODE_VERIFIER_EARLY_EXIT_EN
- Defined:
  - COMPARE → REPORT in the cycle of the first mismatch.
  - mismatch_count is then 1 on failure.
  - Failure latency = mismatched index + 2 edges.
  - Success latency is unchanged.
- Undefined: the full DIGITS-cycle compare always runs, and mismatch_count is the exact count.

Decomposition:
- Package code_verifier_pkg holds:
  - typedef enum logic [1:0] {IDLE, COMPARE, REPORT, HOLD} cv_state_t
  - localparam default DIGIT_W/DIGITS
- Sub-module digit_buffer holds the capture register file, saturating digits_entered counter, clear input and indexed read port.
- code_verifier keeps the FSM, compare index and result registers.

Test Plan:
- Enter 1,2,3,4; start → final_analysis pulses once, 5 edges after start sampled; match=1, mismatch_count=0, busy high for 5 cycles.
- Enter 1,2,9,4; start → match=0, mismatch_count=1; with EARLY_EXIT_EN, final_analysis comes after 4 edges, count=1.
- Enter 1,2 only; start → match=0, mismatch_count=2 (missing digits count); digits_entered=2.
- Enter 1,2,3,4,5,6 → digits_entered saturates at 4, buffer holds 1,2,3,4; verify → match=1. digit_valid with start in the same cycle → digit dropped.
- Assert rst during COMPARE (idx=2) → all outputs 0 immediately; no final_analysis pulse; a new entry of 1,2,3,4 then verifies with match=1.
- From HOLD, drop start and raise waiting_for_user → IDLE with digits_entered=0, match=0; a fresh sequence verifies correctly.
